wb_dcache_mb_controller: RTL and testbench

Parametrised write-back data-cache controller with multi-beat line transfers, an optional victim-cache path and saturating hit/miss counters. It sits between the LSU/MMU request port, the data-cache datapath (tag/data arrays), the victim cache and the data-memory bus. It sequences lookup, victim swap, write-back, refill and whole-cache flush, transferring one `BEATS`-long line per memory burst.

---
 rtl/wb_dcache_mb_controller.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_wb_dcache_mb_controller.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_dcache_mb_controller.sv
// Write-back data-cache controller with multi-beat line transfers.
// Sequences lookup, victim swap, write-back, refill and whole-cache flush
// between the LSU/MMU port, the cache datapath, the victim cache and the
// data-memory bus. One BEATS-long line moves per memory burst.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   lsu_req_i/lsu_wr_i       request and write qualifier (registered internally)
//   dmem_sel_i               request targets cacheable data memory
//   kill_i, flush_i          abort current request / start whole-cache flush
//   lsu_ack_o                one-cycle completion pulse
//   cache_hit_i/evict_i      tag match / selected line is valid and dirty
//   cache_wr_o               word write into the cache
//   cache_line_wr_o          write refill beat beat_idx_o
//   cache_wrb_req_o          read dirty beat beat_idx_o for write-back
//   cache_line_clean_o       clear the dirty bit at evict_index_o
//   evict_index_o            flush index (registered)
//   beat_idx_o               current burst beat (registered)
//   v_hit_i/v_swap_o/v_wr_en_o  victim-cache hit, swap-in, insert
//   mem_req_o/mem_wr_o/mem_ack_i/mem_kill_o  data-memory bus
//   hit_cnt_o/miss_cnt_o     saturating hit and miss counters (registered)
module wb_dcache_mb_controller #(
  parameter int unsigned IDX_BITS  = 7,
  parameter int unsigned BEATS     = 4,
  parameter bit          VICTIM_EN = 1'b1,
  parameter int unsigned CNT_W     = 32,
  localparam int unsigned BEAT_BITS = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lsu_req_i,
  input  logic                 lsu_wr_i,
  input  logic                 dmem_sel_i,
  input  logic                 kill_i,
  input  logic                 flush_i,
  output logic                 lsu_ack_o,
  input  logic                 cache_hit_i,
  input  logic                 cache_evict_i,
  output logic                 cache_wr_o,
  output logic                 cache_line_wr_o,
  output logic                 cache_wrb_req_o,
  output logic                 cache_line_clean_o,
  output logic [IDX_BITS-1:0]  evict_index_o,
  output logic [BEAT_BITS-1:0] beat_idx_o,
  input  logic                 v_hit_i,
  output logic                 v_swap_o,
  output logic                 v_wr_en_o,
  output logic                 mem_req_o,
  output logic                 mem_wr_o,
  input  logic                 mem_ack_i,
  output logic                 mem_kill_o,
  output logic [CNT_W-1:0]     hit_cnt_o,
  output logic [CNT_W-1:0]     miss_cnt_o
);

  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS - 1);
  localparam logic [IDX_BITS-1:0]  IDX_LAST  = '1;
  localparam logic [CNT_W-1:0]     CNT_MAX   = '1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOOKUP,
    S_VSWAP,
    S_WRITE_BACK,
    S_ALLOCATE,
    S_FLUSH_CHK,
    S_FLUSH_WB,
    S_FLUSH_NEXT,
    S_FLUSH_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [BEAT_BITS-1:0] beat_q, beat_d;
  logic [IDX_BITS-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]     hit_cnt_q, miss_cnt_q;
  logic                 req_q, wr_q, sel_q;
  logic                 replay_q, replay_d;    // LOOKUP is a replay; access already counted
  logic                 last_wb_q, last_wb_d;  // all-ones index has just been written back
  logic                 hit_inc, miss_inc;
  logic                 abort;
  logic                 last_beat;
  logic                 v_hit;

  assign last_beat = (beat_q == LAST_BEAT);
  assign v_hit     = VICTIM_EN && v_hit_i;

  assign evict_index_o = idx_q;
  assign beat_idx_o    = beat_q;
  assign hit_cnt_o     = hit_cnt_q;
  assign miss_cnt_o    = miss_cnt_q;

  // Next-state and combinational outputs
  always_comb begin
    state_d            = state_q;
    beat_d             = beat_q;
    idx_d              = idx_q;
    replay_d           = replay_q;
    last_wb_d          = last_wb_q;
    hit_inc            = 1'b0;
    miss_inc           = 1'b0;
    abort              = 1'b0;
    lsu_ack_o          = 1'b0;
    cache_wr_o         = 1'b0;
    cache_line_wr_o    = 1'b0;
    cache_wrb_req_o    = 1'b0;
    cache_line_clean_o = 1'b0;
    v_swap_o           = 1'b0;
    v_wr_en_o          = 1'b0;
    mem_req_o          = 1'b0;
    mem_wr_o           = 1'b0;
    mem_kill_o         = 1'b0;

    case (state_q)
      S_IDLE: begin
        replay_d  = 1'b0;
        last_wb_d = 1'b0;
        beat_d    = '0;
        idx_d     = '0;
        if (flush_i)    state_d = S_FLUSH_CHK;
        else if (req_q) state_d = S_LOOKUP;
      end

      S_LOOKUP: begin
        // Lookup decisions use the registered request qualifiers
        abort = kill_i | ~sel_q;
        if (cache_hit_i) begin
          lsu_ack_o  = 1'b1;
          cache_wr_o = wr_q;
          hit_inc    = ~replay_q;
          state_d    = S_IDLE;
        end else if (v_hit) begin
          hit_inc = 1'b1;
          state_d = S_VSWAP;
        end else begin
          miss_inc        = 1'b1;
          v_wr_en_o       = VICTIM_EN;
          mem_req_o       = 1'b1;
          mem_wr_o        = cache_evict_i;
          cache_wrb_req_o = cache_evict_i;
          state_d         = cache_evict_i ? S_WRITE_BACK : S_ALLOCATE;
        end
      end

      S_VSWAP: begin
        abort    = kill_i | ~dmem_sel_i;
        v_swap_o = 1'b1;
        replay_d = 1'b1;
        state_d  = S_LOOKUP;
      end

      S_WRITE_BACK: begin
        abort           = kill_i | ~dmem_sel_i;
        mem_req_o       = 1'b1;
        mem_wr_o        = 1'b1;
        cache_wrb_req_o = 1'b1;
        if (mem_ack_i) begin
          if (last_beat) begin
            // Refill request starts in the same cycle as the final write beat
            beat_d   = '0;
            mem_wr_o = 1'b0;
            state_d  = S_ALLOCATE;
          end else begin
            beat_d = beat_q + BEAT_BITS'(1);
          end
        end
      end

      S_ALLOCATE: begin
        abort     = kill_i | ~dmem_sel_i;
        mem_req_o = 1'b1;
        if (mem_ack_i) begin
          cache_line_wr_o = 1'b1;
          if (last_beat) begin
            beat_d   = '0;
            replay_d = 1'b1;
            state_d  = S_LOOKUP;
          end else begin
            beat_d = beat_q + BEAT_BITS'(1);
          end
        end
      end

      S_FLUSH_CHK: begin
        abort = kill_i;
        if (cache_evict_i) begin
          mem_req_o       = 1'b1;
          mem_wr_o        = 1'b1;
          cache_wrb_req_o = 1'b1;
          state_d         = S_FLUSH_WB;
        end else if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = S_FLUSH_DONE;
        end else begin
          idx_d   = idx_q + IDX_BITS'(1);
          state_d = S_FLUSH_NEXT;
        end
      end

      S_FLUSH_WB: begin
        abort           = kill_i;
        mem_req_o       = 1'b1;
        mem_wr_o        = 1'b1;
        cache_wrb_req_o = 1'b1;
        if (mem_ack_i) begin
          if (last_beat) begin
            beat_d             = '0;
            cache_line_clean_o = 1'b1;
            state_d            = S_FLUSH_NEXT;
            if (idx_q == IDX_LAST) last_wb_d = 1'b1;
            else                   idx_d     = idx_q + IDX_BITS'(1);
          end else begin
            beat_d = beat_q + BEAT_BITS'(1);
          end
        end
      end

      S_FLUSH_NEXT: begin
        abort = kill_i;
        if (last_wb_q) begin
          idx_d     = '0;
          last_wb_d = 1'b0;
          state_d   = S_FLUSH_DONE;
        end else begin
          state_d = S_FLUSH_CHK;
        end
      end

      S_FLUSH_DONE: begin
        lsu_ack_o = 1'b1;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Abort drops the request, silences the datapath and kills the bus transaction
    if (abort) begin
      state_d            = S_IDLE;
      beat_d             = '0;
      idx_d              = '0;
      replay_d           = 1'b0;
      last_wb_d          = 1'b0;
      hit_inc            = 1'b0;
      miss_inc           = 1'b0;
      lsu_ack_o          = 1'b0;
      cache_wr_o         = 1'b0;
      cache_line_wr_o    = 1'b0;
      cache_wrb_req_o    = 1'b0;
      cache_line_clean_o = 1'b0;
      v_swap_o           = 1'b0;
      v_wr_en_o          = 1'b0;
      mem_req_o          = 1'b0;
      mem_wr_o           = 1'b0;
      mem_kill_o         = 1'b1;
    end
  end

  // State, beat/index registers, input copies and saturating counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      beat_q     <= '0;
      idx_q      <= '0;
      replay_q   <= 1'b0;
      last_wb_q  <= 1'b0;
      req_q      <= 1'b0;
      wr_q       <= 1'b0;
      sel_q      <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      idx_q     <= idx_d;
      replay_q  <= replay_d;
      last_wb_q <= last_wb_d;
      req_q     <= lsu_req_i;
      wr_q      <= lsu_wr_i;
      sel_q     <= dmem_sel_i;
      if (hit_inc && (hit_cnt_q != CNT_MAX))   hit_cnt_q  <= hit_cnt_q + CNT_W'(1);
      if (miss_inc && (miss_cnt_q != CNT_MAX)) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_wb_dcache_mb_controller.sv
// Self-checking bench for wb_dcache_mb_controller: random accesses against
// an access-level model (hit / victim / clean miss / dirty miss), kill,
// mid-burst reset, flush walks, VICTIM_EN=0 behaviour and counter saturation.
module tb_wb_dcache_mb_controller;
  localparam int IDX_BITS  = 2;
  localparam int BEATS     = 4;
  localparam int CNT_W     = 4;
  localparam int BEAT_BITS = 2;
  localparam int CNT_MAX   = 15;
  localparam int TIMEOUT   = 300;

  logic clk, rst, rst0;
  logic lsu_req_i, lsu_wr_i, dmem_sel_i, kill_i, flush_i;
  logic cache_hit_i, cache_evict_i, v_hit_i, mem_ack_i;

  logic lsu_ack_o, cache_wr_o, cache_line_wr_o, cache_wrb_req_o, cache_line_clean_o;
  logic v_swap_o, v_wr_en_o, mem_req_o, mem_wr_o, mem_kill_o;
  logic [IDX_BITS-1:0]  evict_index_o;
  logic [BEAT_BITS-1:0] beat_idx_o;
  logic [CNT_W-1:0]     hit_cnt_o, miss_cnt_o;

  logic nv_lsu_ack_o, nv_cache_wr_o, nv_cache_line_wr_o, nv_cache_wrb_req_o, nv_cache_line_clean_o;
  logic nv_v_swap_o, nv_v_wr_en_o, nv_mem_req_o, nv_mem_wr_o, nv_mem_kill_o;
  logic [IDX_BITS-1:0]  nv_evict_index_o;
  logic [BEAT_BITS-1:0] nv_beat_idx_o;
  logic [CNT_W-1:0]     nv_hit_cnt_o, nv_miss_cnt_o;

  int checks = 0;
  int fails  = 0;
  int hit_m  = 0;
  int miss_m = 0;

  wb_dcache_mb_controller #(.IDX_BITS(IDX_BITS), .BEATS(BEATS), .VICTIM_EN(1'b1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .lsu_req_i(lsu_req_i), .lsu_wr_i(lsu_wr_i), .dmem_sel_i(dmem_sel_i),
    .kill_i(kill_i), .flush_i(flush_i), .lsu_ack_o(lsu_ack_o),
    .cache_hit_i(cache_hit_i), .cache_evict_i(cache_evict_i),
    .cache_wr_o(cache_wr_o), .cache_line_wr_o(cache_line_wr_o),
    .cache_wrb_req_o(cache_wrb_req_o), .cache_line_clean_o(cache_line_clean_o),
    .evict_index_o(evict_index_o), .beat_idx_o(beat_idx_o),
    .v_hit_i(v_hit_i), .v_swap_o(v_swap_o), .v_wr_en_o(v_wr_en_o),
    .mem_req_o(mem_req_o), .mem_wr_o(mem_wr_o), .mem_ack_i(mem_ack_i),
    .mem_kill_o(mem_kill_o), .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  wb_dcache_mb_controller #(.IDX_BITS(IDX_BITS), .BEATS(BEATS), .VICTIM_EN(1'b0), .CNT_W(CNT_W)) dut_nv (
    .clk(clk), .rst(rst0),
    .lsu_req_i(lsu_req_i), .lsu_wr_i(lsu_wr_i), .dmem_sel_i(dmem_sel_i),
    .kill_i(kill_i), .flush_i(flush_i), .lsu_ack_o(nv_lsu_ack_o),
    .cache_hit_i(cache_hit_i), .cache_evict_i(cache_evict_i),
    .cache_wr_o(nv_cache_wr_o), .cache_line_wr_o(nv_cache_line_wr_o),
    .cache_wrb_req_o(nv_cache_wrb_req_o), .cache_line_clean_o(nv_cache_line_clean_o),
    .evict_index_o(nv_evict_index_o), .beat_idx_o(nv_beat_idx_o),
    .v_hit_i(v_hit_i), .v_swap_o(nv_v_swap_o), .v_wr_en_o(nv_v_wr_en_o),
    .mem_req_o(nv_mem_req_o), .mem_wr_o(nv_mem_wr_o), .mem_ack_i(mem_ack_i),
    .mem_kill_o(nv_mem_kill_o), .hit_cnt_o(nv_hit_cnt_o), .miss_cnt_o(nv_miss_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  task automatic idle_inputs();
    lsu_req_i = 0; lsu_wr_i = 0; dmem_sel_i = 1; kill_i = 0; flush_i = 0;
    cache_hit_i = 0; cache_evict_i = 0; v_hit_i = 0; mem_ack_i = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    hit_m = 0;
    miss_m = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    @(negedge clk);
    lsu_req_i = 1; flush_i = 1; cache_hit_i = 1; mem_ack_i = 1; lsu_wr_i = 1;
    #1;
    checks++; if ({lsu_ack_o, cache_wr_o, cache_line_wr_o, cache_wrb_req_o, cache_line_clean_o} !== 5'b0) begin
      fails++; $display("FAIL reset_cache_outs: got %b want 00000", {lsu_ack_o, cache_wr_o, cache_line_wr_o, cache_wrb_req_o, cache_line_clean_o}); end
    checks++; if ({v_swap_o, v_wr_en_o, mem_req_o, mem_wr_o, mem_kill_o} !== 5'b0) begin
      fails++; $display("FAIL reset_bus_outs: got %b want 00000", {v_swap_o, v_wr_en_o, mem_req_o, mem_wr_o, mem_kill_o}); end
    checks++; if (hit_cnt_o !== 4'd0 || miss_cnt_o !== 4'd0) begin
      fails++; $display("FAIL reset_counters: got hit %0d miss %0d want 0 0", hit_cnt_o, miss_cnt_o); end
    checks++; if (evict_index_o !== 2'd0 || beat_idx_o !== 2'd0) begin
      fails++; $display("FAIL reset_index_beat: got idx %0d beat %0d want 0 0", evict_index_o, beat_idx_o); end
    do_reset();
  endtask

  // One LSU access; the bench plays datapath, victim cache and memory.
  task automatic run_access(input bit hit, input bit vict, input bit dirty, input bit wr);
    int  n_ack, ack_cyc, last_ref_cyc, n_wb, n_ref, n_swap, n_vwr, n_cwr, n_req, beat_err, wr_err, exp_cyc;
    bit  present, req_prev, miss_mem;
    n_ack = 0; ack_cyc = -1; last_ref_cyc = -1; n_wb = 0; n_ref = 0; n_swap = 0; n_vwr = 0;
    n_cwr = 0; n_req = 0; beat_err = 0; wr_err = 0; present = hit; req_prev = 0;
    miss_mem = !hit && !vict;
    for (int c = 0; c < TIMEOUT; c++) begin
      @(negedge clk);
      lsu_req_i = (c == 0); lsu_wr_i = wr; dmem_sel_i = 1;
      cache_hit_i = present; cache_evict_i = dirty; v_hit_i = vict; mem_ack_i = 0;
      #1;
      if (mem_req_o && req_prev && ($urandom_range(0, 2) != 0)) begin
        mem_ack_i = 1;
        #1;
      end
      if (mem_ack_i) begin
        if (cache_wrb_req_o) begin
          if (int'(beat_idx_o) != n_wb) beat_err++;
          if (mem_wr_o !== (n_wb != BEATS - 1)) wr_err++;
          n_wb++;
        end else begin
          if (!cache_line_wr_o || int'(beat_idx_o) != n_ref) beat_err++;
          n_ref++;
          if (n_ref == BEATS) begin present = 1; last_ref_cyc = c; end
        end
      end else if (mem_req_o && cache_wrb_req_o && mem_wr_o !== 1'b1) begin
        wr_err++;
      end
      if (cache_line_wr_o && !mem_ack_i) beat_err++;
      n_req  += int'(mem_req_o);
      n_swap += int'(v_swap_o);
      n_vwr  += int'(v_wr_en_o);
      n_cwr  += int'(cache_wr_o);
      if (v_swap_o) present = 1;
      if (lsu_ack_o) begin n_ack++; if (ack_cyc < 0) ack_cyc = c; end
      req_prev = mem_req_o;
      if (ack_cyc >= 0 && c >= ack_cyc + 2) break;
    end
    idle_inputs();
    if (hit || vict) hit_m = sat(hit_m + 1);
    else             miss_m = sat(miss_m + 1);
    exp_cyc = hit ? 2 : (vict ? 4 : last_ref_cyc + 1);

    checks++; if (n_ack != 1) begin fails++; $display("FAIL ack_count: got %0d want 1 (h%0d v%0d d%0d)", n_ack, hit, vict, dirty); end
    checks++; if (ack_cyc != exp_cyc) begin fails++; $display("FAIL ack_latency: got %0d want %0d (h%0d v%0d d%0d)", ack_cyc, exp_cyc, hit, vict, dirty); end
    checks++; if (n_wb != ((miss_mem && dirty) ? BEATS : 0)) begin fails++; $display("FAIL wb_beats: got %0d want %0d", n_wb, (miss_mem && dirty) ? BEATS : 0); end
    checks++; if (n_ref != (miss_mem ? BEATS : 0)) begin fails++; $display("FAIL refill_beats: got %0d want %0d", n_ref, miss_mem ? BEATS : 0); end
    checks++; if (n_swap != int'(!hit && vict)) begin fails++; $display("FAIL v_swap_count: got %0d want %0d", n_swap, int'(!hit && vict)); end
    checks++; if (n_vwr != int'(miss_mem)) begin fails++; $display("FAIL v_wr_en_count: got %0d want %0d", n_vwr, int'(miss_mem)); end
    checks++; if (n_cwr != int'(wr)) begin fails++; $display("FAIL cache_wr_count: got %0d want %0d", n_cwr, int'(wr)); end
    checks++; if ((n_req != 0) != miss_mem) begin fails++; $display("FAIL mem_req_seen: got %0d cycles want any=%0d", n_req, miss_mem); end
    checks++; if (beat_err != 0) begin fails++; $display("FAIL beat_sequence: got %0d errors want 0", beat_err); end
    checks++; if (wr_err != 0) begin fails++; $display("FAIL mem_wr_pattern: got %0d errors want 0", wr_err); end
    checks++; if (int'(hit_cnt_o) != hit_m) begin fails++; $display("FAIL hit_cnt: got %0d want %0d", hit_cnt_o, hit_m); end
    checks++; if (int'(miss_cnt_o) != miss_m) begin fails++; $display("FAIL miss_cnt: got %0d want %0d", miss_cnt_o, miss_m); end
  endtask

  task automatic test_random_access();
    int sc;
    for (int i = 0; i < 24; i++) begin
      sc = int'($urandom_range(0, 3));
      run_access(sc == 0, sc == 1, sc == 3, 1'($urandom));
    end
  endtask

  task automatic test_directed_access();
    run_access(1, 0, 0, 0);  // read hit
    run_access(0, 0, 1, 0);  // dirty miss
    run_access(0, 1, 0, 1);  // victim hit, write
  endtask

  task automatic test_kill();
    int n_ack;
    @(negedge clk); lsu_req_i = 1; cache_hit_i = 0; cache_evict_i = 0; v_hit_i = 0;
    @(negedge clk); lsu_req_i = 0;
    @(negedge clk);                      // LOOKUP, miss issued
    @(negedge clk); mem_ack_i = 1;       // ALLOCATE beat 0
    @(negedge clk); kill_i = 1;          // ALLOCATE beat 1 with kill
    #1;
    checks++; if (beat_idx_o !== 2'd1) begin fails++; $display("FAIL kill_beat_before: got %0d want 1", beat_idx_o); end
    checks++; if (mem_kill_o !== 1'b1) begin fails++; $display("FAIL kill_mem_kill: got %b want 1", mem_kill_o); end
    checks++; if ({cache_line_wr_o, mem_req_o, lsu_ack_o} !== 3'b000) begin
      fails++; $display("FAIL kill_forced_low: got %b want 000", {cache_line_wr_o, mem_req_o, lsu_ack_o}); end
    @(negedge clk); kill_i = 0; mem_ack_i = 0;
    #1;
    checks++; if (beat_idx_o !== 2'd0 || mem_kill_o !== 1'b0) begin
      fails++; $display("FAIL kill_after: got beat %0d kill %b want 0 0", beat_idx_o, mem_kill_o); end
    n_ack = int'(lsu_ack_o);
    repeat (5) begin @(negedge clk); #1; n_ack += int'(lsu_ack_o); end
    miss_m = sat(miss_m + 1);
    checks++; if (n_ack != 0) begin fails++; $display("FAIL kill_no_ack: got %0d acks want 0", n_ack); end
    checks++; if (int'(miss_cnt_o) != miss_m) begin fails++; $display("FAIL kill_miss_cnt: got %0d want %0d", miss_cnt_o, miss_m); end
    idle_inputs();
    run_access(1, 0, 0, 1);  // controller is back in IDLE
  endtask

  task automatic test_midburst_reset();
    @(negedge clk); lsu_req_i = 1; cache_evict_i = 1;
    @(negedge clk); lsu_req_i = 0;
    @(negedge clk);                      // LOOKUP dirty miss
    @(negedge clk); mem_ack_i = 1;       // WRITE_BACK beat 0
    @(negedge clk); mem_ack_i = 0;
    #2 rst = 1;
    #1;
    checks++; if ({mem_kill_o, mem_req_o, mem_wr_o, cache_wrb_req_o} !== 4'b0 || beat_idx_o !== 2'd0) begin
      fails++; $display("FAIL midburst_reset: got %b beat %0d want 0000 beat 0", {mem_kill_o, mem_req_o, mem_wr_o, cache_wrb_req_o}, beat_idx_o); end
    do_reset();
  endtask

  task automatic test_flush(input logic [3:0] mask);
    logic [3:0] d;
    int  got_code, exp_code, n_wb, n_ack, ack_cyc;
    bit  req_prev;
    d = mask; got_code = 0; exp_code = 0; n_wb = 0; n_ack = 0; ack_cyc = -1; req_prev = 0;
    for (int i = 0; i < 4; i++) if (mask[i]) exp_code = exp_code * 8 + i + 1;
    for (int c = 0; c < TIMEOUT; c++) begin
      @(negedge clk);
      flush_i = (c == 0);
      cache_evict_i = d[evict_index_o];
      mem_ack_i = 0;
      #1;
      if (mem_req_o && req_prev && ($urandom_range(0, 2) != 0)) begin
        mem_ack_i = 1;
        #1;
      end
      if (mem_ack_i && cache_wrb_req_o) n_wb++;
      if (cache_line_clean_o) begin
        got_code = got_code * 8 + int'(evict_index_o) + 1;
        d[evict_index_o] = 1'b0;
      end
      if (lsu_ack_o) begin n_ack++; if (ack_cyc < 0) ack_cyc = c; end
      req_prev = mem_req_o;
      if (ack_cyc >= 0 && c >= ack_cyc + 1) break;
    end
    idle_inputs();
    checks++; if (got_code != exp_code) begin fails++; $display("FAIL flush_clean_order: got %0o want %0o (mask %b)", got_code, exp_code, mask); end
    checks++; if (n_wb != BEATS * $countones(mask)) begin fails++; $display("FAIL flush_wb_beats: got %0d want %0d", n_wb, BEATS * $countones(mask)); end
    checks++; if (n_ack != 1) begin fails++; $display("FAIL flush_ack: got %0d want 1", n_ack); end
    checks++; if (d !== 4'b0) begin fails++; $display("FAIL flush_left_dirty: got %b want 0000", d); end
    checks++; if (evict_index_o !== 2'd0) begin fails++; $display("FAIL flush_index_end: got %0d want 0", evict_index_o); end
    checks++; if (int'(hit_cnt_o) != hit_m || int'(miss_cnt_o) != miss_m) begin
      fails++; $display("FAIL flush_counters: got %0d %0d want %0d %0d", hit_cnt_o, miss_cnt_o, hit_m, miss_m); end
  endtask

  task automatic test_no_victim();
    rst = 1;
    @(negedge clk); #1;
    checks++; if ({nv_lsu_ack_o, nv_cache_wr_o, nv_cache_line_wr_o, nv_cache_wrb_req_o, nv_cache_line_clean_o,
                   nv_v_swap_o, nv_v_wr_en_o, nv_mem_req_o, nv_mem_wr_o, nv_mem_kill_o,
                   nv_evict_index_o, nv_beat_idx_o, nv_hit_cnt_o, nv_miss_cnt_o} !== '0) begin
      fails++; $display("FAIL nv_reset_outputs: got nonzero want all 0"); end
    rst0 = 0;
    @(negedge clk); lsu_req_i = 1; cache_hit_i = 0; cache_evict_i = 0; v_hit_i = 1;
    @(negedge clk); lsu_req_i = 0;
    @(negedge clk); #1;                  // LOOKUP: victim hit ignored
    checks++; if ({nv_mem_req_o, nv_v_wr_en_o, nv_v_swap_o, nv_mem_wr_o} !== 4'b1000) begin
      fails++; $display("FAIL nv_lookup: got %b want 1000", {nv_mem_req_o, nv_v_wr_en_o, nv_v_swap_o, nv_mem_wr_o}); end
    @(negedge clk); #1;                  // ALLOCATE
    checks++; if (nv_mem_req_o !== 1'b1 || nv_v_swap_o !== 1'b0) begin
      fails++; $display("FAIL nv_allocate: got req %b swap %b want 1 0", nv_mem_req_o, nv_v_swap_o); end
    checks++; if (nv_miss_cnt_o !== 4'd1 || nv_hit_cnt_o !== 4'd0) begin
      fails++; $display("FAIL nv_counters: got hit %0d miss %0d want 0 1", nv_hit_cnt_o, nv_miss_cnt_o); end
    rst0 = 1;
    do_reset();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 17; i++) run_access(1, 0, 0, 1'($urandom));
    checks++; if (hit_cnt_o !== 4'd15) begin fails++; $display("FAIL hit_cnt_saturate: got %0d want 15", hit_cnt_o); end
  endtask

  initial begin
    rst = 1; rst0 = 1;
    idle_inputs();
    test_reset();
    test_directed_access();
    test_random_access();
    test_kill();
    test_midburst_reset();
    test_flush(4'b0010);
    test_flush(4'b1001);
    test_flush(4'($urandom));
    test_flush(4'b0000);
    test_no_victim();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
